// File: rtl/pio_btn_capture_if.sv
// Avalon-MM slave bus of the button PIO: register select, write strobe, read data and interrupt.
// Avalon-MM: a write takes effect on the rising edge where chipselect=1 and write_n=0; readdata follows address with one cycle of latency.
interface pio_btn_capture_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/pio_btn_capture.sv
// Debounced button/switch PIO with edge capture, interrupt mask and an Avalon-MM register port.
// Each input is synchronized, debounced per bit, and accepted edges latch into EDGE_CAPTURE.
module pio_btn_capture #(
  parameter int WIDTH           = 2,
  parameter int EDGE_TYPE       = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pio_btn_capture_if.slave     bus,
  input  logic [WIDTH-1:0]     in_port
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_stable;
  logic [CW-1:0]    r_cnt [WIDTH];
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_cap;
  logic [31:0]      r_readdata;

  logic             w_wr;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_accept;
  logic [WIDTH-1:0] w_set;
  logic [31:0]      w_rd;
  logic             w_unused;

  assign w_unused = &{1'b0, bus.writedata};
  assign w_wr     = bus.chipselect & ~bus.write_n;
  assign w_clr    = (w_wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

  // A bit is accepted on the edge where it has differed for DEBOUNCE_CYCLES s2-cycles.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_accept[i] = (r_s2[i] != r_stable[i]) && (r_cnt[i] == CNT_MAX);
    end
  end

  always_comb begin
    w_set = '0;
    case (EDGE_TYPE)
      0:       w_set = w_accept & r_s2;
      1:       w_set = w_accept & ~r_s2;
      default: w_set = w_accept;
    endcase
  end

  always_comb begin
    w_rd = '0;
    case (bus.address)
      2'd0:    w_rd[WIDTH-1:0] = r_stable;
      2'd2:    w_rd[WIDTH-1:0] = r_irq_mask;
      2'd3:    w_rd[WIDTH-1:0] = r_edge_cap;
      default: w_rd = '0;
    endcase
  end

  // Reset to all ones: the idle level of active-low buttons, so release produces no spurious edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1     <= '1;
      r_s2     <= '1;
      r_stable <= '1;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      r_s1     <= in_port;
      r_s2     <= r_s1;
      r_stable <= r_stable ^ w_accept;
      for (int i = 0; i < WIDTH; i++) begin
        if (r_s2[i] == r_stable[i] || w_accept[i]) r_cnt[i] <= '0;
        else                                        r_cnt[i] <= r_cnt[i] + CW'(1);
      end
    end
  end

  // A capture set on the same edge as a clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_mask <= '0;
      r_edge_cap <= '0;
      r_readdata <= '0;
    end else begin
      if (w_wr && bus.address == 2'd2) r_irq_mask <= bus.writedata[WIDTH-1:0];
      r_edge_cap <= (r_edge_cap & ~w_clr) | w_set;
      r_readdata <= w_rd;
    end
  end

  assign bus.readdata = r_readdata;
  assign bus.irq      = |(r_edge_cap & r_irq_mask);

endmodule

// File: tb/tb_pio_btn_capture.sv
// Directed bench for pio_btn_capture (WIDTH=2, falling edge, DEBOUNCE_CYCLES=4) with a queue-based scoreboard.
module tb_pio_btn_capture;

  logic       clk;
  logic       reset_n;
  logic [1:0] in_port;
  int         n_checks = 0;
  int         n_errors = 0;

  logic [31:0] exp_q [$];
  logic        kind_q[$];
  string       name_q[$];

  logic [31:0] mon_exp;
  logic [31:0] mon_got;
  logic        mon_kind;
  string       mon_name;

  pio_btn_capture_if bus ();

  pio_btn_capture #(
    .WIDTH           (2),
    .EDGE_TYPE       (1),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .in_port (in_port)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(negedge clk);
  endtask

  task automatic exp_rd(input logic [31:0] e, input string nm);
    exp_q.push_back(e);
    kind_q.push_back(1'b0);
    name_q.push_back(nm);
  endtask

  task automatic exp_irq(input logic e, input string nm);
    exp_q.push_back({31'b0, e});
    kind_q.push_back(1'b1);
    name_q.push_back(nm);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input logic ei, input string nm);
    bus.address = a;
    step();
    exp_rd(e, nm);
    exp_irq(ei, {nm, "_irq"});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic cs);
    bus.address    = a;
    bus.chipselect = cs;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    step();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
  endtask

  // scoreboard monitor: drains expectations #1 after each falling edge
  always @(negedge clk) begin
    #1;
    while (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_kind = kind_q.pop_front();
      mon_name = name_q.pop_front();
      mon_got  = mon_kind ? {31'b0, bus.irq} : bus.readdata;
      n_checks++;
      if (mon_got !== mon_exp) begin
        n_errors++;
        $display("FAIL %s: got %h expected %h", mon_name, mon_got, mon_exp);
      end
    end
  end

  initial begin
    #100000;
    n_errors++;
    $display("FAIL timeout: bench did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    reset_n        = 1'b0;
    in_port        = 2'b11;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;

    step();
    exp_rd(32'h0, "reset_readdata");
    exp_irq(1'b0, "reset_irq");
    step();
    reset_n = 1'b1;

    // idle reads after reset
    rd(2'd0, 32'h3, 1'b0, "idle_data");
    rd(2'd2, 32'h0, 1'b0, "idle_mask");
    rd(2'd3, 32'h0, 1'b0, "idle_cap");

    // falling edge on bit 0: accepted exactly at edge k+5
    bus.address = 2'd0;
    in_port     = 2'b10;
    for (int i = 0; i <= 6; i++) begin
      step();
      exp_rd((i <= 5) ? 32'h3 : 32'h2, $sformatf("fall0_data_e%0d", i));
    end
    rd(2'd3, 32'h1, 1'b0, "fall0_cap");
    wr(2'd2, 32'h1, 1'b1);
    exp_irq(1'b1, "mask_irq");
    rd(2'd2, 32'h1, 1'b1, "mask_read");

    // 3-cycle glitch on bit 1 is rejected
    in_port = 2'b00;
    repeat (3) step();
    in_port = 2'b10;
    repeat (6) step();
    rd(2'd0, 32'h2, 1'b1, "glitch3_data");
    rd(2'd3, 32'h1, 1'b1, "glitch3_cap");

    // 4-cycle pulse on bit 1 is accepted, rising return is not captured
    in_port = 2'b00;
    repeat (4) step();
    in_port = 2'b10;
    repeat (10) step();
    rd(2'd0, 32'h2, 1'b1, "pulse4_data");
    rd(2'd3, 32'h3, 1'b1, "pulse4_cap");

    // write-1-to-clear
    wr(2'd2, 32'h3, 1'b1);
    exp_irq(1'b1, "mask3_irq");
    wr(2'd3, 32'h1, 1'b1);
    exp_irq(1'b1, "clr1_irq");
    rd(2'd3, 32'h2, 1'b1, "clr1_cap");
    wr(2'd3, 32'h2, 1'b1);
    exp_irq(1'b0, "clr2_irq");
    rd(2'd3, 32'h0, 1'b0, "clr2_cap");

    // set beats a coincident clear
    in_port = 2'b11;
    repeat (10) step();
    rd(2'd3, 32'h0, 1'b0, "rise0_cap");
    in_port = 2'b10;
    repeat (5) step();
    wr(2'd3, 32'h1, 1'b1);
    rd(2'd3, 32'h1, 1'b1, "setwins_cap");
    wr(2'd0, 32'h0, 1'b1);
    rd(2'd0, 32'h2, 1'b1, "ro_data");
    wr(2'd2, 32'h0, 1'b0);
    rd(2'd2, 32'h3, 1'b1, "nocs_mask");

    // reset two cycles into a debounce
    in_port = 2'b00;
    repeat (4) step();
    reset_n = 1'b0;
    exp_rd(32'h0, "midrst_readdata");
    exp_irq(1'b0, "midrst_irq");
    bus.address = 2'd0;
    repeat (2) step();
    reset_n = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      step();
      exp_rd((i <= 5) ? 32'h3 : 32'h0, $sformatf("postrst_data_e%0d", i));
    end
    rd(2'd3, 32'h3, 1'b0, "postrst_cap");
    rd(2'd2, 32'h0, 1'b0, "postrst_mask");

    #3;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
